lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Multi-cycle load/store controller between the core's data-access control fields (`data_req`, `data_byte`, `data_wr`, `zero_extnd`) and a request/grant/response data-memory port. Sequences each access through a small FSM, generates byte enables and lane-replicated write data, aligns and sign/zero-extends load data, and stalls the core until the access completes. Misaligned accesses and memory timeouts are detected and reported without corrupting memory.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles spent in REQ+WAIT before abort; counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `clk  in  1`  system clock, rising edge.
- `rst  in  1`  asynchronous, active-high reset.
- `lsu_req_i  in  1`  access requested (control `data_req`); held by core while stalled.
- `lsu_wr_i  in  1`  1 = store, 0 = load (control `data_wr`).
- `lsu_size_i  in  2`  `mem_encode`: Byte/Halfword/Word; Reserved is illegal.
- `lsu_zero_extnd_i  in  1`  1 = zero-extend load, 0 = sign-extend.
- `lsu_addr_i  in  32`  byte address from ALU.
- `lsu_wdata_i  in  32`  store data (rs2).
- `lsu_stall_o  out  1`  freeze PC/regfile write.
- `lsu_done_o  out  1`  one-cycle completion pulse.
- `lsu_rdata_o  out  32`  extended load result, valid while `lsu_done_o`.
- `lsu_misalign_o  out  1`  pulse with done: misaligned or Reserved size.
- `lsu_err_o  out  1`  pulse with done: timeout.
- `mem_req_o  out  1`, `mem_gnt_i  in  1`, `mem_we_o  out  1`, `mem_be_o  out  4`, `mem_addr_o  out  32` (word-aligned, `[1:0]`=0), `mem_wdata_o  out  32`, `mem_rvalid_i  in  1`, `mem_rdata_i  in  32`.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on `lsu_req_i`, check alignment. Legal → register addr/be/wdata/we/size/zero_extnd, go REQ. Illegal (half with addr[0]=1, word with addr[1:0]≠0, size Reserved) → go DONE with misalign flag set, no bus activity.
- REQ: `mem_req_o`=1, all bus outputs stable; on `mem_gnt_i` → WAIT.
- WAIT: `mem_req_o`=0; on `mem_rvalid_i` (loads and stores both acknowledged) capture `mem_rdata_i` → DONE.
- DONE: `lsu_done_o`=1, flags and `lsu_rdata_o` valid; unconditionally → IDLE. Request seen in DONE is not re-issued (core advances this cycle).
- Timeout: counter clears on IDLE→REQ, increments in REQ/WAIT; reaching `TIMEOUT_CYCLES` → DONE with err flag, `mem_req_o` dropped, `lsu_rdata_o`=0.
- `mem_rvalid_i`/`mem_gnt_i` outside their states are ignored.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011` (addr[1]=0) or `4'b1100`; word `4'b1111`.
- Write data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word as-is.
- Load: shift `mem_rdata_i` right by `addr[1:0]*8`, take 8/16/32 bits, extend per `zero_extnd`.
- Misalign/err results: `lsu_rdata_o`=0.

## Timing
- `lsu_stall_o = lsu_req_i && state != DONE` (combinational).
- Minimum legal access: cycle 0 IDLE (stall), 1 REQ+gnt, 2 WAIT+rvalid, 3 DONE → 3 stall cycles.
- Misaligned: cycle 0 IDLE, cycle 1 DONE → 1 stall cycle.
- `mem_rvalid_i` earliest one cycle after grant.
- Reset: state IDLE; all outputs 0 immediately (async), including `mem_req_o` mid-REQ; in-flight response discarded.

## Structure
- Shared package gains `lsu_state_e` (IDLE/REQ/WAIT/DONE); reuses existing `mem_encode`.
- One combinational sub-module `lsu_align`: byte enables, write replication, load extract/extend, misalign detection.

## Test plan
- Word load addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF → `mem_be_o`=4'b1111, stall 3 cycles, rdata 0xDEADBEEF.
- LB addr 0x103, mem word 0x80FF_FF12, sign-extend → be 4'b1000, rdata 0xFFFFFF80; same with LBU → 0x00000080.
- SH addr 0x102 wdata 0x1234ABCD → be 4'b1100, wdata 0xABCDABCD, we=1; grant delayed 4 cycles → addr/be stable throughout.
- LW addr 0x101 → no `mem_req_o`, done+misalign next cycle, rdata 0; Reserved size → same.
- `TIMEOUT_CYCLES`=8, gnt never asserted → err+done after 8 REQ cycles, `mem_req_o` falls.
- Assert `rst` during WAIT → outputs 0 asynchronously; late rvalid after release ignored, FSM in IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared types for the load/store unit memory controller
//
// Purpose: access-size encoding shared with the core's control fields, the
// LSU sequencing states, and a small address helper.
package lsu_mem_ctrl_pkg;

  // Access size as carried on the core's data_byte control field.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_encode;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  // The memory port only ever sees word addresses; lanes are picked by byte enables.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extraction and misalignment check
//
// Purpose: purely combinational datapath helper for lsu_mem_ctrl.
// Ports:
//   req_size_i / req_addr_lo_i / req_wdata_i : request side (core fields, pre-register)
//   be_o / wdata_o / misalign_o             : byte enables, lane-replicated store data, illegal flag
//   rsp_size_i / rsp_addr_lo_i / rsp_zext_i : registered attributes of the access in flight
//   rsp_rdata_i / rsp_data_o                : raw memory word in, aligned and extended load data out
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  mem_encode   req_size_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  mem_encode   rsp_size_i,
  input  logic [1:0]  rsp_addr_lo_i,
  input  logic        rsp_zext_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [31:0] rsp_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = req_wdata_i;
    misalign_o = 1'b0;
    case (req_size_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << req_addr_lo_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      MEM_HALF: begin
        be_o       = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{req_wdata_i[15:0]}};
        misalign_o = req_addr_lo_i[0];
      end
      MEM_WORD: begin
        be_o       = 4'b1111;
        misalign_o = (req_addr_lo_i != 2'b00);
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = rsp_rdata_i >> {rsp_addr_lo_i, 3'b000};

  always_comb begin
    rsp_data_o = shifted;
    case (rsp_size_i)
      MEM_BYTE: rsp_data_o = {{24{~rsp_zext_i & shifted[7]}}, shifted[7:0]};
      MEM_HALF: rsp_data_o = {{16{~rsp_zext_i & shifted[15]}}, shifted[15:0]};
      default:  rsp_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - multi-cycle load/store controller to a req/gnt/rvalid memory port
//
// Purpose: sequences one core data access at a time (IDLE -> REQ -> WAIT -> DONE),
// stalls the core until completion, and reports misaligned accesses and timeouts.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   lsu_req_i .. lsu_wdata_i    : core access request and attributes
//   lsu_stall_o, lsu_done_o     : core stall and one-cycle completion pulse
//   lsu_rdata_o                 : extended load data, valid with lsu_done_o
//   lsu_misalign_o, lsu_err_o   : completion flags (illegal access / timeout)
//   mem_*                       : request/grant/response data-memory port
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_i,
  input  logic        lsu_wr_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_zero_extnd_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  mem_encode         size_q, size_d;
  logic              zext_q, zext_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_misalign;
  logic [31:0]       al_rsp_data;

  lsu_align u_align (
    .req_size_i    (mem_encode'(lsu_size_i)),
    .req_addr_lo_i (lsu_addr_i[1:0]),
    .req_wdata_i   (lsu_wdata_i),
    .be_o          (al_be),
    .wdata_o       (al_wdata),
    .misalign_o    (al_misalign),
    .rsp_size_i    (size_q),
    .rsp_addr_lo_i (addr_q[1:0]),
    .rsp_zext_i    (zext_q),
    .rsp_rdata_i   (mem_rdata_i),
    .rsp_data_o    (al_rsp_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= MEM_BYTE;
      zext_q     <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      zext_q     <= zext_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    size_d     = size_q;
    zext_d     = zext_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    err_d      = err_q;

    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          if (al_misalign) begin
            // Illegal access never touches the bus; report it on the next cycle.
            misalign_d = 1'b1;
            state_d    = LSU_DONE;
          end else begin
            misalign_d = 1'b0;
            addr_d     = lsu_addr_i;
            be_d       = al_be;
            wdata_d    = al_wdata;
            we_d       = lsu_wr_i;
            size_d     = mem_encode'(lsu_size_i);
            zext_d     = lsu_zero_extnd_i;
            cnt_d      = '0;
            state_d    = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = LSU_DONE;
        end else if (mem_gnt_i) begin
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the last allowed cycle still counts as success.
        if (mem_rvalid_i) begin
          rdata_d = al_rsp_data;
          state_d = LSU_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  assign lsu_stall_o    = lsu_req_i && (state_q != LSU_DONE);
  assign lsu_done_o     = (state_q == LSU_DONE);
  assign lsu_rdata_o    = lsu_done_o ? rdata_q : '0;
  assign lsu_misalign_o = lsu_done_o && misalign_q;
  assign lsu_err_o      = lsu_done_o && err_q;

  assign mem_req_o   = (state_q == LSU_REQ);
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
  assign mem_addr_o  = word_align(addr_q);
  assign mem_wdata_o = wdata_q;

endmodule
